// File: rtl/lut2_vector_eval.sv
// Bitwise evaluator of any 2-input Boolean function over WIDTH-bit operands,
// with a single-cycle parallel mode and an LSB-first bit-serial mode.
module lut2_vector_eval #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] ones
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PAR, SER} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       func_q;
  logic [WIDTH-1:0] sh;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] acc;

  logic [WIDTH-1:0] par_res_c;
  logic             ser_bit_c;
  logic [WIDTH-1:0] sh_next_c;
  logic [CNT_W-1:0] acc_next_c;

  function automatic logic [WIDTH-1:0] lut_vec(input logic [3:0] f,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(WIDTH); i++) r[i] = f[{x[i], y[i]}];
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] pop_cnt(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(WIDTH); i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Serial step: evaluate the bit at idx into the staging register.
  always_comb begin
    par_res_c  = lut_vec(func_q, a_q, b_q);
    ser_bit_c  = func_q[{a_q[idx], b_q[idx]}];
    sh_next_c  = sh;
    sh_next_c[idx] = ser_bit_c;
    acc_next_c = acc + CNT_W'(ser_bit_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      func_q <= '0;
      sh     <= '0;
      idx    <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ones   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            func_q <= func;
            sh     <= '0;
            idx    <= '0;
            acc    <= '0;
            busy   <= 1'b1;
            state  <= mode ? SER : PAR;
          end
        end
        PAR: begin
          result <= par_res_c;
          ones   <= pop_cnt(par_res_c);
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        SER: begin
          sh  <= sh_next_c;
          acc <= acc_next_c;
          if (idx == LAST_IDX) begin
            result <= sh_next_c;
            ones   <= acc_next_c;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
